// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//
// Purpose:
//   Arbitrates N_REQ producers onto the single write port of a FIFO. A producer
//   that wins arbitration owns the port for a burst of up to BURST_MAX
//   consecutive pushes. Ownership then passes round-robin to the next producer
//   after the owner. Accepts are combinational, so a beat is taken in the same
//   cycle it is granted. No push is ever issued while the FIFO reports full.
//
// Ports:
//   clk          in   1                 single clock, rising edge
//   rst          in   1                 synchronous active-high reset
//   req          in   N_REQ             per-producer push request
//   req_data     in   N_REQ*W_WIDTH     producer i data in [i*W_WIDTH +: W_WIDTH]
//   full         in   1                 FIFO full flag
//   gnt          out  N_REQ             one-hot-or-zero accept (data taken now)
//   push         out  1                 FIFO push strobe
//   in_data      out  W_WIDTH           FIFO write data (0 when not pushing)
//   owner        out  clog2(N_REQ)      current or most recent burst owner
//   blocked_cnt  out  16                saturating count of full-stall cycles
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_WIDTH   = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W_WIDTH-1:0]   req_data,
    input  logic                       full,
    output logic [N_REQ-1:0]           gnt,
    output logic                       push,
    output logic [W_WIDTH-1:0]         in_data,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic [15:0]                blocked_cnt
);

    localparam int OW = $clog2(N_REQ);
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,   // no owner; next cycle with a request starts a burst
        OWN  = 1'b1    // owner locked until burst limit or owner drops req
    } state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [BW-1:0]   beat_cnt, beat_nxt;

    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [BW-1:0]   beat_inc;
    logic            burst_done;

    // Index of the producer that follows idx, wrapping at N_REQ (which need
    // not be a power of two).
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        if (int'(idx) == N_REQ - 1) begin
            return '0;
        end
        return idx + OW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin search: first asserted request starting at rr_ptr.
    // -------------------------------------------------------------------------
    always_comb begin
        int cand;
        // NOTE: every variable written in a combinational block gets a default
        // at the top; otherwise a path that skips the assignment infers a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'(cand);
            end
        end
    end

    // The grant that brings beat_cnt up to BURST_MAX closes the burst.
    assign beat_inc   = beat_cnt + BW'(1);
    assign burst_done = (beat_inc == BW'(BURST_MAX));

    // -------------------------------------------------------------------------
    // Next-state and grant logic. Reset and full both force the accept path
    // off; with full=1 every register holds, so a stalled burst resumes exactly
    // where it stopped once space frees up.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        beat_nxt   = beat_cnt;
        gnt        = '0;

        if (!rst && !full) begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt[pick_idx] = 1'b1;
                        owner_nxt     = pick_idx;
                        beat_nxt      = BW'(1);
                        if (BURST_MAX == 1) begin
                            // A one-beat burst is already complete: stay idle
                            // and move the pointer past the winner.
                            rr_ptr_nxt = wrap_inc(pick_idx);
                        end else begin
                            state_nxt = OWN;
                        end
                    end
                end

                OWN: begin
                    if (req[owner]) begin
                        gnt[owner] = 1'b1;
                        beat_nxt   = beat_inc;
                        if (burst_done) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = wrap_inc(owner);
                        end
                    end else begin
                        // Owner withdrew mid-burst: release ownership. This
                        // cycle carries no grant; the next producer is picked
                        // from IDLE on the following cycle.
                        state_nxt  = IDLE;
                        rr_ptr_nxt = wrap_inc(owner);
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Write-port drive: data of the granted producer, zero otherwise.
    // -------------------------------------------------------------------------
    assign push = |gnt;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                in_data = req_data[i*W_WIDTH +: W_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Stall counter: counts cycles in which some producer wanted to push but
    // the FIFO was full. Sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            blocked_cnt <= '0;
        end else if (full && (|req) && (blocked_cnt != 16'hFFFF)) begin
            blocked_cnt <= blocked_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_push_arbiter
//
// Table of directed per-cycle vectors, a long full-stall saturation run, and a
// randomized run compared against a behavioural model of the arbitration rules.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_fifo_push_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BM    = 4;
    localparam int BOUND = (N - 1) * (BM + 1) + 1;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic             full;
    logic [N-1:0]     gnt;
    logic             push;
    logic [W-1:0]     in_data;
    logic [1:0]       owner;
    logic [15:0]      blocked_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_push_arbiter #(
        .N_REQ     (N),
        .W_WIDTH   (W),
        .BURST_MAX (BM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .full        (full),
        .gnt         (gnt),
        .push        (push),
        .in_data     (in_data),
        .owner       (owner),
        .blocked_cnt (blocked_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One directed cycle: inputs plus expected outputs. Registered outputs
    // (blocked_cnt, owner) show the value after the previous clock edges.
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic [3:0]  gnt;
        logic [7:0]  dat;
        bit          chk_blk;
        logic [15:0] blk;
        bit          chk_own;
        logic [1:0]  own;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t row(input logic r, input logic [3:0] rq, input logic f,
                                 input logic [3:0] g, input logic [7:0] d,
                                 input bit cb = 0, input logic [15:0] b = '0,
                                 input bit co = 0, input logic [1:0] o = '0);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f; v.gnt = g; v.dat = d;
        v.chk_blk = cb; v.blk = b; v.chk_own = co; v.own = o;
        return v;
    endfunction

    task automatic apply_row(input vec_t v, input int n);
        @(negedge clk);
        rst  = v.rst;
        req  = v.req;
        full = v.full;
        #1;
        check($sformatf("row%0d gnt", n), 32'(gnt), 32'(v.gnt));
        check($sformatf("row%0d push", n), 32'(push), 32'(|v.gnt));
        check($sformatf("row%0d in_data", n), 32'(in_data), 32'(v.dat));
        if (v.chk_blk) check($sformatf("row%0d blocked_cnt", n), 32'(blocked_cnt), 32'(v.blk));
        if (v.chk_own) check($sformatf("row%0d owner", n), 32'(owner), 32'(v.own));
    endtask

    // Behavioural reference state for the random run.
    int          m_busy, m_owner, m_beats, m_ptr, m_blk;
    int          wait_cnt[N];
    logic [3:0]  prev_eg;

    initial begin
        int pushes;
        rst = 1'b1; req = '0; full = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'hA0 + i);

        // ---------------- directed vector table ----------------
        vecs.push_back(row(1, 4'hF, 0, 4'h0, 8'h00));
        vecs.push_back(row(1, 4'hF, 1, 4'h0, 8'h00, 1, 16'd0, 1, 2'd0));
        // Only producer 1 requests for 6 cycles: no bubble at the burst boundary.
        for (int i = 0; i < 6; i++)
            vecs.push_back(row(0, 4'h2, 0, 4'h2, 8'hA1, (i == 0), 16'd0, (i == 5), 2'd1));
        vecs.push_back(row(0, 4'h0, 0, 4'h0, 8'h00, 0, 0, 1, 2'd1));
        vecs.push_back(row(1, 4'h0, 0, 4'h0, 8'h00));
        // All request: bursts of 4 in round-robin order, then back to 0.
        for (int i = 0; i < 17; i++)
            vecs.push_back(row(0, 4'hF, 0, 4'(1 << ((i / 4) % 4)), 8'(8'hA0 + (i / 4) % 4),
                               0, 0, (i % 4 == 1), 2'((i / 4) % 4)));
        vecs.push_back(row(1, 4'h0, 0, 4'h0, 8'h00));
        // Full stall for 3 cycles in the middle of owner 0's burst.
        vecs.push_back(row(0, 4'h1, 0, 4'h1, 8'hA0));
        vecs.push_back(row(0, 4'h1, 0, 4'h1, 8'hA0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(row(0, 4'h1, 1, 4'h0, 8'h00, 0, 0, (i == 0), 2'd0));
        vecs.push_back(row(0, 4'h1, 0, 4'h1, 8'hA0, 1, 16'd3));
        vecs.push_back(row(0, 4'h1, 0, 4'h1, 8'hA0));
        vecs.push_back(row(0, 4'h0, 0, 4'h0, 8'h00, 1, 16'd3, 1, 2'd0));
        vecs.push_back(row(1, 4'h0, 0, 4'h0, 8'h00));
        // Owner 0 drops after 2 beats with producer 2 waiting: one bubble.
        vecs.push_back(row(0, 4'h5, 0, 4'h1, 8'hA0));
        vecs.push_back(row(0, 4'h5, 0, 4'h1, 8'hA0));
        vecs.push_back(row(0, 4'h4, 0, 4'h0, 8'h00));
        vecs.push_back(row(0, 4'h4, 0, 4'h4, 8'hA2));
        vecs.push_back(row(0, 4'h0, 0, 4'h0, 8'h00, 0, 0, 1, 2'd2));
        vecs.push_back(row(1, 4'h0, 0, 4'h0, 8'h00));
        // Reset in the middle of owner 2's burst.
        for (int i = 0; i < 10; i++)
            vecs.push_back(row(0, 4'hF, 0, 4'(1 << (i / 4)), 8'(8'hA0 + i / 4)));
        vecs.push_back(row(0, 4'hF, 1, 4'h0, 8'h00));
        vecs.push_back(row(1, 4'hF, 0, 4'h0, 8'h00, 1, 16'd1, 1, 2'd2));
        vecs.push_back(row(0, 4'hF, 0, 4'h1, 8'hA0, 1, 16'd0, 1, 2'd0));
        vecs.push_back(row(0, 4'hF, 0, 4'h1, 8'hA0));

        foreach (vecs[i]) apply_row(vecs[i], i);

        // ---------------- blocked_cnt saturation ----------------
        @(negedge clk); rst = 1'b1; req = '0; full = 1'b0;
        @(negedge clk); rst = 1'b0; req = 4'h1; full = 1'b1;
        pushes = 0;
        for (int i = 0; i < 70000; i++) begin
            #1;
            if (push || (gnt != '0)) pushes++;
            @(negedge clk);
        end
        #1;
        check("sat push_while_full", 32'(pushes), 32'd0);
        check("sat blocked_cnt", 32'(blocked_cnt), 32'hFFFF);
        @(negedge clk); full = 1'b0; #1;
        check("sat release gnt", 32'(gnt), 32'h1);

        // ---------------- randomized run vs. model ----------------
        @(negedge clk); rst = 1'b1; req = '0; full = 1'b0;
        m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_blk = 0;
        prev_eg = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        @(negedge clk); rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] eg;
            logic [7:0] ed;
            int found;
            if (cyc != 0) @(negedge clk);
            // Producers hold request and data until accepted; after an accept
            // they either offer a new beat or withdraw.
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (prev_eg[i]) begin
                        if ($urandom_range(1, 0) == 1) req_data[i*W +: W] = 8'($urandom);
                        else req[i] = 1'b0;
                    end
                end else if ($urandom_range(9, 0) < 3) begin
                    req[i] = 1'b1;
                    req_data[i*W +: W] = 8'($urandom);
                end
            end
            full = ($urandom_range(4, 0) == 0);
            #1;
            check("rnd owner", 32'(owner), 32'(m_owner));
            check("rnd blocked_cnt", 32'(blocked_cnt), 32'(m_blk));

            eg = '0; ed = '0; found = -1;
            if (full) begin
                if (req != '0 && m_blk < 65535) m_blk++;
            end else if (m_busy == 0) begin
                for (int k = 0; k < N; k++)
                    if (found < 0 && req[(m_ptr + k) % N]) found = (m_ptr + k) % N;
                if (found >= 0) begin
                    m_owner = found;
                    m_beats = 1;
                    if (m_beats == BM) m_ptr = (found + 1) % N;
                    else m_busy = 1;
                end
            end else if (req[m_owner]) begin
                found = m_owner;
                m_beats++;
                if (m_beats == BM) begin
                    m_busy = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % N;
            end
            if (found >= 0) begin
                eg[found] = 1'b1;
                ed = req_data[found*W +: W];
            end
            check("rnd gnt", 32'(gnt), 32'(eg));
            check("rnd push", 32'(push), 32'(|eg));
            check("rnd in_data", 32'(in_data), 32'(ed));

            // Waiting time of each pending producer, in non-full cycles.
            for (int i = 0; i < N; i++) begin
                if (!req[i]) wait_cnt[i] = 0;
                else if (!full) begin
                    wait_cnt[i]++;
                    if (gnt[i]) begin
                        check($sformatf("rnd starvation p%0d", i), 32'(wait_cnt[i] <= BOUND), 32'd1);
                        wait_cnt[i] = 0;
                    end
                end
            end
            prev_eg = eg;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- N_REQ, 4, number of producers, range 2..8.
- W_WIDTH, 8, push data width, matching the FIFO write port.
- BURST_MAX, 4, maximum consecutive pushes per ownership, range 1..16.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- req, in, N_REQ, per-producer push request.
- req_data, in, N_REQ*W_WIDTH, producer i data in bits [i*W_WIDTH +: W_WIDTH].
- full, in, 1, FIFO full flag.
- gnt, out, N_REQ, one-hot-or-zero accept; data taken this cycle.
- push, out, 1, FIFO push strobe.
- in_data, out, W_WIDTH, FIFO write data.
- owner, out, clog2(N_REQ), current or last burst owner.
- blocked_cnt, out, 16, saturating count of full-stall cycles.

REQ-003 Clock and reset SHALL be exactly as decided: one clock `clk`; reset `rst` is synchronous and active-high.

Function
REQ-004 State machine SHALL have two states, IDLE (no owner) and OWN (owner locked). Internal registers: rr_ptr, owner, beat_cnt.
REQ-005 gnt, push and in_data SHALL be combinational from state, req and full, giving a same-cycle accept.
- push = |gnt.
- in_data = granted producer's data, else 0.
REQ-006 In IDLE, with |req and !full:
- Grant the first asserted req scanning rr_ptr, rr_ptr+1, ... with modulo N_REQ wrap.
- Load owner with the granted index; set beat_cnt=1.
- Go to OWN, unless BURST_MAX==1, in which case stay IDLE and set rr_ptr=owner+1 mod N_REQ.
REQ-007 In OWN, gnt[owner] SHALL equal req[owner] & !full; each grant increments beat_cnt.
REQ-008 OWN SHALL return to IDLE with rr_ptr=owner+1 mod N_REQ when either:
- the grant making beat_cnt==BURST_MAX occurs (transition at end of that cycle), or
- req[owner] is low in OWN; that cycle carries no grant (one-cycle bubble).
REQ-009 With full=1, gnt SHALL be 0 and push SHALL be 0 in every state; state, owner, beat_cnt and rr_ptr hold.
REQ-010 blocked_cnt SHALL increment when full=1 and |req=1, and saturate at 0xFFFF.
REQ-011 Producers SHALL hold req and data stable until granted. The arbiter does not queue requests and never drops a granted beat.
REQ-012 push SHALL never assert while full=1, so the FIFO push_err_on_full is never caused by this block.
REQ-013 Starvation bound: a continuously asserted req SHALL be granted within (N_REQ-1)*(BURST_MAX+1)+1 non-full cycles.

Reset
REQ-014 While rst=1:
- state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, blocked_cnt=0.
- gnt=0, push=0, in_data=0, regardless of req and full.
REQ-015 Reset asserted mid-burst SHALL abandon the burst with no push in the reset cycle; arbitration restarts from producer 0 on the first cycle after rst falls.

Verification
REQ-016 The bench SHALL cover these directed scenarios (N_REQ=4, BURST_MAX=4):
- Only req[1] held for 6 cycles, full=0 -> gnt=0x2 in all 6 cycles, 6 pushes, owner=1, no bubble at the burst boundary.
- req=0xF held continuously, data i=0xA0+i -> in_data sequence A0 x4, A1 x4, A2 x4, A3 x4, then A0 again.
- full=1 for 3 cycles after 2 beats of owner 0 -> gnt=0 and push=0 for those 3 cycles, blocked_cnt=3, then owner 0 resumes for beats 3-4.
- Owner 0 drops req after 2 beats with req[2] pending -> one cycle with push=0, then gnt=0x4.
- rst=1 for 1 cycle during owner 2's burst with req=0xF -> that cycle push=0 and blocked_cnt=0; next grant is gnt=0x1.
- full=1 and req=0x1 held 70000 cycles -> blocked_cnt=0xFFFF with no wrap and push never asserted.
